npu_agu: RTL and testbench
==========================

Name: npu_agu

Overview:
- Address generation unit for the NPU datapath.
- Holds four independent registered address counters:
  - memory word address (16b)
  - byte address (16b)
  - feedback/buffer pointer (6b)
  - row/column counter (8b)
- Each counter is loaded from a latched 40-bit transfer descriptor and stepped by per-generator enables issued by the transfer controller.
- Outputs drive SRAM, byte-lane and buffer addressing directly.

Parameters:
- MEM_W, 16, width of memory address generator.
- BYTE_W, 16, width of byte address generator.
- FB_W, 6, width of feedback buffer pointer.
- RC_W, 8, width of row/column counter.

Ports:
- sys_clk  in  1  system clock; all state updates on its rising edge.
- clear_agu  in  1  reset, synchronous, active-high; clears all generators.
- latch_tr_addresses  in  40  transfer descriptor.
  - [15:0] mem init address
  - [31:16] byte init address
  - [39:32] rc init value
- latch_tr_control  in  4  transfer mode.
  - [1:0] mem stride code
  - [2] byte direction
  - [3] rc mode
- mem_gen_ldinit  in  1  load mem generator from descriptor.
- mem_gen_enable  in  1  advance mem generator by stride.
- byte_gen_ldinit  in  1  load byte generator from descriptor.
- byte_gen_enable  in  1  advance byte generator by 1.
- fb_gen_enable  in  1  advance fb pointer by 1 (no load input).
- rc_gen_ldinit  in  1  load rc counter from descriptor.
- rc_gen_enable  in  1  step rc counter.
- mem_gen_oaddr  out  16  current memory address (registered).
- byte_gen_oaddr  out  16  current byte address (registered).
- fb_gen_oaddr  out  6  current fb pointer (registered).
- rc_gen_oaddr  out  8  current rc count (registered).

Behaviour:
- Clocking/reset (already decided): one clock, sys_clk; reset clear_agu is synchronous and active-high.
- Reset: while clear_agu is high at a rising edge, all four outputs become 0. clear_agu has priority over every load/enable.
- Every output is the register itself; no combinational path from inputs to outputs. Latency: a change is visible 1 cycle after the edge sampling ldinit/enable.
- Priority per generator: clear_agu > ldinit > enable > hold.
- Generators are fully independent; any combination may be active in the same cycle.
- Descriptor and control are sampled live at each edge; there are no internal copies.
- Mem generator:
  - load: mem <= addresses[15:0].
  - step: mem <= mem + stride, with stride 1/2/4/8 for control[1:0] = 00/01/10/11.
  - Modulo 2^16 wrap (e.g. 0xFFFC + 4 = 0x0000).
- Byte generator:
  - load: byte <= addresses[31:16].
  - step: control[2]=0 gives +1, control[2]=1 gives -1.
  - Modulo 2^16 wrap both ways.
- FB generator:
  - No load. step: fb <= fb + 1, mod 64 (0x3F -> 0x00).
  - Returns to 0 only via clear_agu or wrap.
- RC generator:
  - load: rc <= addresses[39:32].
  - step with control[3]=0: rc + 1, mod 256.
  - step with control[3]=1: rc - 1, saturating at 0 (holds 0, no wrap).
- Enable held high steps the generator every cycle. ldinit held high reloads every cycle.
- Control changing mid-sequence takes effect at the next step; current value is not rescaled.

Decomposition:
- Shared package agu_pkg holds:
  - descriptor field offsets (MEM_LO=0, BYTE_LO=16, RC_LO=32)
  - control bit indices
  - stride code constants (STRIDE_1/2/4/8)
  - function stride_decode(code) returning 16-bit increment.
- One sub-module is natural: agu_counter, parameterized WIDTH.
  - Inputs: clk, clr, ld, en, init, step, dir, sat.
  - Output: registered value.
  - Instantiated four times. fb uses ld tied 0, init 0, step 1.

Test Plan:
- Reset: preset generators to non-zero, pulse clear_agu one cycle -> all four outputs 0 on the next edge. clear_agu asserted with all ldinit/enable high -> outputs still 0.
- Mem load+stride: addresses=0x00_0001_9000, control=4'b0010. mem_gen_ldinit one cycle -> mem_gen_oaddr=0x9000. Then mem_gen_enable 3 cycles -> 0x9004, 0x9008, 0x900C. Load 0xFFFC and step -> 0x0000.
- Byte up/down: same descriptor, byte_gen_ldinit -> 0x0001. Enable 2 cycles -> 0x0003. Set control[2]=1, enable 4 cycles -> 0x0002, 0x0001, 0x0000, 0xFFFF.
- FB wrap: after clear, fb_gen_enable 63 cycles -> 0x3F. One more cycle -> 0x00. Enable low -> holds.
- RC modes: addresses[39:32]=0x05, rc_gen_ldinit. control[3]=1, enable 7 cycles -> 4, 3, 2, 1, 0, 0, 0. Reload 0xFF with control[3]=0, enable 1 cycle -> 0x00.
- Priority/concurrency: ldinit and enable together -> init value loaded (no step). All seven controls toggled as an incrementing 7-bit pattern {mem_ld, mem_en, byte_ld, byte_en, fb_en, rc_ld, rc_en} for 128 cycles -> each output matches an independent reference model every cycle.

Source files
------------

// File: rtl/npu_agu_pkg.sv
// Shared constants for the NPU address generation unit.
package agu_pkg;

  // Generator widths
  localparam int unsigned MEM_W  = 16;
  localparam int unsigned BYTE_W = 16;
  localparam int unsigned FB_W   = 6;
  localparam int unsigned RC_W   = 8;

  // Descriptor and control widths
  localparam int unsigned DESC_W = 40;
  localparam int unsigned CTL_W  = 4;

  // Descriptor field offsets
  localparam int unsigned MEM_LO  = 0;
  localparam int unsigned BYTE_LO = 16;
  localparam int unsigned RC_LO   = 32;

  // Control bit indices
  localparam int unsigned CTL_STRIDE_LO = 0;
  localparam int unsigned CTL_STRIDE_HI = 1;
  localparam int unsigned CTL_BYTE_DIR  = 2;
  localparam int unsigned CTL_RC_MODE   = 3;

  // Memory stride codes
  localparam logic [1:0] STRIDE_1 = 2'b00;
  localparam logic [1:0] STRIDE_2 = 2'b01;
  localparam logic [1:0] STRIDE_4 = 2'b10;
  localparam logic [1:0] STRIDE_8 = 2'b11;

  // Stride code to memory address increment
  function automatic logic [MEM_W-1:0] stride_decode(input logic [1:0] code);
    logic [MEM_W-1:0] inc;
    inc = MEM_W'(1);
    case (code)
      STRIDE_1: inc = MEM_W'(1);
      STRIDE_2: inc = MEM_W'(2);
      STRIDE_4: inc = MEM_W'(4);
      STRIDE_8: inc = MEM_W'(8);
      default:  inc = MEM_W'(1);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/npu_agu_if.sv
// Transfer-controller to AGU bus: descriptor, control, strobes and addresses.
interface npu_agu_if;
  import agu_pkg::*;

  logic [DESC_W-1:0] latch_tr_addresses;
  logic [CTL_W-1:0]  latch_tr_control;
  logic              mem_gen_ldinit;
  logic              mem_gen_enable;
  logic              byte_gen_ldinit;
  logic              byte_gen_enable;
  logic              fb_gen_enable;
  logic              rc_gen_ldinit;
  logic              rc_gen_enable;
  logic [MEM_W-1:0]  mem_gen_oaddr;
  logic [BYTE_W-1:0] byte_gen_oaddr;
  logic [FB_W-1:0]   fb_gen_oaddr;
  logic [RC_W-1:0]   rc_gen_oaddr;

  // Transfer controller side
  modport master (
    output latch_tr_addresses, latch_tr_control,
    output mem_gen_ldinit, mem_gen_enable,
    output byte_gen_ldinit, byte_gen_enable,
    output fb_gen_enable,
    output rc_gen_ldinit, rc_gen_enable,
    input  mem_gen_oaddr, byte_gen_oaddr, fb_gen_oaddr, rc_gen_oaddr
  );

  // AGU side
  modport slave (
    input  latch_tr_addresses, latch_tr_control,
    input  mem_gen_ldinit, mem_gen_enable,
    input  byte_gen_ldinit, byte_gen_enable,
    input  fb_gen_enable,
    input  rc_gen_ldinit, rc_gen_enable,
    output mem_gen_oaddr, byte_gen_oaddr, fb_gen_oaddr, rc_gen_oaddr
  );

endinterface

// File: rtl/npu_agu_counter.sv
// Generic registered address counter: clear > load > step > hold.
// dir=1 steps down; with sat=1 a down-step holds at zero instead of wrapping.
module agu_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] step,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] value
);

  // Counter register with prioritized clear/load/step
  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (ld) begin
      value <= init;
    end else if (en) begin
      if (!dir) begin
        value <= value + step;
      end else if (!(sat && (value == '0))) begin
        value <= value - step;
      end
    end
  end

endmodule

// File: rtl/npu_agu.sv
// NPU address generation unit: four independent address counters
// loaded from the live transfer descriptor and stepped by controller strobes.
module npu_agu
  import agu_pkg::*;
(
  input  logic       sys_clk,
  input  logic       clear_agu,
  npu_agu_if.slave   bus
);

  logic [MEM_W-1:0]  mem_q;
  logic [BYTE_W-1:0] byte_q;
  logic [FB_W-1:0]   fb_q;
  logic [RC_W-1:0]   rc_q;
  logic [MEM_W-1:0]  mem_step;

  assign mem_step = stride_decode(bus.latch_tr_control[CTL_STRIDE_HI:CTL_STRIDE_LO]);

  // Memory word address: strided, wraps modulo 2^16
  agu_counter #(.WIDTH(MEM_W)) u_mem (
    .clk   (sys_clk),
    .clr   (clear_agu),
    .ld    (bus.mem_gen_ldinit),
    .en    (bus.mem_gen_enable),
    .init  (bus.latch_tr_addresses[MEM_LO +: MEM_W]),
    .step  (mem_step),
    .dir   (1'b0),
    .sat   (1'b0),
    .value (mem_q)
  );

  // Byte address: +/-1, wraps both ways
  agu_counter #(.WIDTH(BYTE_W)) u_byte (
    .clk   (sys_clk),
    .clr   (clear_agu),
    .ld    (bus.byte_gen_ldinit),
    .en    (bus.byte_gen_enable),
    .init  (bus.latch_tr_addresses[BYTE_LO +: BYTE_W]),
    .step  (BYTE_W'(1)),
    .dir   (bus.latch_tr_control[CTL_BYTE_DIR]),
    .sat   (1'b0),
    .value (byte_q)
  );

  // Feedback buffer pointer: increment only, no load
  agu_counter #(.WIDTH(FB_W)) u_fb (
    .clk   (sys_clk),
    .clr   (clear_agu),
    .ld    (1'b0),
    .en    (bus.fb_gen_enable),
    .init  ('0),
    .step  (FB_W'(1)),
    .dir   (1'b0),
    .sat   (1'b0),
    .value (fb_q)
  );

  // Row/column counter: up wraps, down saturates at zero
  agu_counter #(.WIDTH(RC_W)) u_rc (
    .clk   (sys_clk),
    .clr   (clear_agu),
    .ld    (bus.rc_gen_ldinit),
    .en    (bus.rc_gen_enable),
    .init  (bus.latch_tr_addresses[RC_LO +: RC_W]),
    .step  (RC_W'(1)),
    .dir   (bus.latch_tr_control[CTL_RC_MODE]),
    .sat   (1'b1),
    .value (rc_q)
  );

  assign bus.mem_gen_oaddr  = mem_q;
  assign bus.byte_gen_oaddr = byte_q;
  assign bus.fb_gen_oaddr   = fb_q;
  assign bus.rc_gen_oaddr   = rc_q;

endmodule

// File: tb/tb_npu_agu.sv
// Testbench for npu_agu: directed vector table, fb wrap sequence,
// and an incrementing strobe pattern with random descriptors vs a reference model.
module tb_npu_agu;

  logic clk;
  logic clr;

  npu_agu_if bus ();

  npu_agu dut (
    .sys_clk   (clk),
    .clear_agu (clr),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state
  int m_mem, m_byte, m_fb, m_rc;

  typedef struct {
    logic        clr;
    logic [6:0]  ctl;   // {mem_ld, mem_en, byte_ld, byte_en, fb_en, rc_ld, rc_en}
    logic [39:0] addr;
    logic [3:0]  ctrl;
    logic [15:0] e_mem;
    logic [15:0] e_byte;
    logic [5:0]  e_fb;
    logic [7:0]  e_rc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic [6:0] s, logic [39:0] a, logic [3:0] k,
                              logic [15:0] em, logic [15:0] eb, logic [5:0] ef, logic [7:0] er);
    vec_t v;
    v.clr = c; v.ctl = s; v.addr = a; v.ctrl = k;
    v.e_mem = em; v.e_byte = eb; v.e_fb = ef; v.e_rc = er;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: next state from the inputs seen at the coming edge
  task automatic model_step();
    int stride;
    if (clr) begin
      m_mem = 0; m_byte = 0; m_fb = 0; m_rc = 0;
    end else begin
      stride = 1 << int'(bus.latch_tr_control[1:0]);
      if (bus.mem_gen_ldinit)       m_mem = int'(bus.latch_tr_addresses[15:0]);
      else if (bus.mem_gen_enable)  m_mem = (m_mem + stride) % 65536;
      if (bus.byte_gen_ldinit)      m_byte = int'(bus.latch_tr_addresses[31:16]);
      else if (bus.byte_gen_enable)
        m_byte = bus.latch_tr_control[2] ? (m_byte + 65535) % 65536 : (m_byte + 1) % 65536;
      if (bus.fb_gen_enable)        m_fb = (m_fb + 1) % 64;
      if (bus.rc_gen_ldinit)        m_rc = int'(bus.latch_tr_addresses[39:32]);
      else if (bus.rc_gen_enable) begin
        if (bus.latch_tr_control[3]) m_rc = (m_rc == 0) ? 0 : m_rc - 1;
        else                         m_rc = (m_rc + 1) % 256;
      end
    end
  endtask

  task automatic drive(input logic c, input logic [6:0] s, input logic [39:0] a, input logic [3:0] k);
    clr                    = c;
    bus.mem_gen_ldinit     = s[6];
    bus.mem_gen_enable     = s[5];
    bus.byte_gen_ldinit    = s[4];
    bus.byte_gen_enable    = s[3];
    bus.fb_gen_enable      = s[2];
    bus.rc_gen_ldinit      = s[1];
    bus.rc_gen_enable      = s[0];
    bus.latch_tr_addresses = a;
    bus.latch_tr_control   = k;
  endtask

  // Advance one edge with the model, sampling 1 time unit after the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".mem"},  int'(bus.mem_gen_oaddr),  m_mem);
    check({tag, ".byte"}, int'(bus.byte_gen_oaddr), m_byte);
    check({tag, ".fb"},   int'(bus.fb_gen_oaddr),   m_fb);
    check({tag, ".rc"},   int'(bus.rc_gen_oaddr),   m_rc);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_mem = 0; m_byte = 0; m_fb = 0; m_rc = 0;
    drive(1'b1, 7'h00, 40'h0, 4'h0);

    // Reset and preset/clear
    vecs.push_back(mk(1, 7'b0000000, 40'h00_0000_0000, 4'b0000, 16'h0000, 16'h0000, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b1010110, 40'h05_0001_9000, 4'b0000, 16'h9000, 16'h0001, 6'h01, 8'h05));
    vecs.push_back(mk(1, 7'b1111111, 40'h05_0001_9000, 4'b0000, 16'h0000, 16'h0000, 6'h00, 8'h00));
    // Mem load and stride 4, then wrap
    vecs.push_back(mk(0, 7'b1000000, 40'h00_0001_9000, 4'b0010, 16'h9000, 16'h0000, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0100000, 40'h00_0001_9000, 4'b0010, 16'h9004, 16'h0000, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0100000, 40'h00_0001_9000, 4'b0010, 16'h9008, 16'h0000, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0100000, 40'h00_0001_9000, 4'b0010, 16'h900C, 16'h0000, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b1000000, 40'h00_0001_FFFC, 4'b0010, 16'hFFFC, 16'h0000, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0100000, 40'h00_0001_FFFC, 4'b0010, 16'h0000, 16'h0000, 6'h00, 8'h00));
    // Byte up then down through zero
    vecs.push_back(mk(0, 7'b0010000, 40'h00_0001_9000, 4'b0010, 16'h0000, 16'h0001, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0001000, 40'h00_0001_9000, 4'b0010, 16'h0000, 16'h0002, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0001000, 40'h00_0001_9000, 4'b0010, 16'h0000, 16'h0003, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0001000, 40'h00_0001_9000, 4'b0110, 16'h0000, 16'h0002, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0001000, 40'h00_0001_9000, 4'b0110, 16'h0000, 16'h0001, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0001000, 40'h00_0001_9000, 4'b0110, 16'h0000, 16'h0000, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0001000, 40'h00_0001_9000, 4'b0110, 16'h0000, 16'hFFFF, 6'h00, 8'h00));
    // RC down saturating, then up wrap
    vecs.push_back(mk(0, 7'b0000010, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h05));
    vecs.push_back(mk(0, 7'b0000001, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h04));
    vecs.push_back(mk(0, 7'b0000001, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h03));
    vecs.push_back(mk(0, 7'b0000001, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h02));
    vecs.push_back(mk(0, 7'b0000001, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h01));
    vecs.push_back(mk(0, 7'b0000001, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0000001, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0000001, 40'h05_0001_9000, 4'b1000, 16'h0000, 16'hFFFF, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0000010, 40'hFF_0001_9000, 4'b0000, 16'h0000, 16'hFFFF, 6'h00, 8'hFF));
    vecs.push_back(mk(0, 7'b0000001, 40'hFF_0001_9000, 4'b0000, 16'h0000, 16'hFFFF, 6'h00, 8'h00));
    // Load beats step; control change applies to the next step only
    vecs.push_back(mk(0, 7'b1100000, 40'h00_0001_1234, 4'b0011, 16'h1234, 16'hFFFF, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0011000, 40'h00_ABCD_1234, 4'b0110, 16'h1234, 16'hABCD, 6'h00, 8'h00));
    vecs.push_back(mk(0, 7'b0000011, 40'h7E_ABCD_1234, 4'b1000, 16'h1234, 16'hABCD, 6'h00, 8'h7E));
    vecs.push_back(mk(0, 7'b0100000, 40'h7E_ABCD_1234, 4'b0011, 16'h123C, 16'hABCD, 6'h00, 8'h7E));
    vecs.push_back(mk(0, 7'b0100000, 40'h7E_ABCD_1234, 4'b0000, 16'h123D, 16'hABCD, 6'h00, 8'h7E));

    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ctl, vecs[i].addr, vecs[i].ctrl);
      tick();
      check($sformatf("vec%0d.mem", i),  int'(bus.mem_gen_oaddr),  int'(vecs[i].e_mem));
      check($sformatf("vec%0d.byte", i), int'(bus.byte_gen_oaddr), int'(vecs[i].e_byte));
      check($sformatf("vec%0d.fb", i),   int'(bus.fb_gen_oaddr),   int'(vecs[i].e_fb));
      check($sformatf("vec%0d.rc", i),   int'(bus.rc_gen_oaddr),   int'(vecs[i].e_rc));
    end

    // FB wrap: clear, 63 steps to 0x3F, one more to 0x00, then hold
    drive(1'b1, 7'b0000000, 40'h0, 4'h0);
    tick();
    check_model("fb_clear");
    for (int i = 0; i < 63; i++) begin
      drive(1'b0, 7'b0000100, 40'h0, 4'h0);
      tick();
      check_model($sformatf("fb_up%0d", i));
    end
    check("fb_top", int'(bus.fb_gen_oaddr), 63);
    drive(1'b0, 7'b0000100, 40'h0, 4'h0);
    tick();
    check("fb_wrap", int'(bus.fb_gen_oaddr), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'b0000000, 40'h0, 4'h0);
      tick();
      check($sformatf("fb_hold%0d", i), int'(bus.fb_gen_oaddr), 0);
    end

    // Incrementing strobe pattern with random descriptor/control
    for (int i = 0; i < 128; i++) begin
      logic [39:0] a;
      a = {8'($urandom), 32'($urandom)};
      drive(1'b0, 7'(i), a, 4'($urandom));
      tick();
      check_model($sformatf("pat%0d", i));
    end

    // Random sweep including occasional clears
    for (int i = 0; i < 200; i++) begin
      logic [39:0] a;
      a = {8'($urandom), 32'($urandom)};
      drive(($urandom_range(0, 15) == 0), 7'($urandom), a, 4'($urandom));
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
